// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter and its companion divider.
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StTrack = 2'd2
  } meter_state_e;

  localparam int unsigned DefaultWidth     = 16;
  localparam int unsigned DefaultLockCount = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a registered any-edge (rise or fall) pulse.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_o  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_o  <= sync2_q ^ prev_q;
    end
  end

endmodule

// File: rtl/clk_period_meter.sv
// Measures the half-period of a slow square wave in clk_i cycles and reports lock/timeout.
// Optional loss counter on loss_cnt_o is built when CLK_METER_LOSS_CNT_EN is defined.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned LOCK_COUNT = DefaultLockCount,
  parameter int unsigned MAX_COUNT  = (2 ** WIDTH) - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  output logic [WIDTH-1:0] devider_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             timeout_o
`ifdef CLK_METER_LOSS_CNT_EN
  ,
  output logic [7:0]       loss_cnt_o
`endif
);

  localparam int unsigned MW = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [WIDTH-1:0] MaxCnt   = WIDTH'(MAX_COUNT);
  localparam logic [MW-1:0]    MatchMax = MW'(LOCK_COUNT - 1);

  meter_state_e     state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [MW-1:0]    match_q;
  logic             sig_edge;

  logic take_meas, is_match, is_timeout, lock_drop;

  sync_edge_det u_sync_edge_det (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (sig_i),
    .edge_o (sig_edge)
  );

  // An edge always wins over a simultaneous timeout.
  always_comb begin
    take_meas  = sig_edge && (state_q != StIdle);
    is_match   = take_meas && (state_q == StTrack) && (cnt_q == devider_o);
    is_timeout = !sig_edge && (state_q != StIdle) && (cnt_q == MaxCnt);
    lock_drop  = locked_o && ((take_meas && !is_match) || is_timeout);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      match_q      <= '0;
      devider_o    <= '0;
      meas_valid_o <= 1'b0;
      locked_o     <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      meas_valid_o <= take_meas;
      timeout_o    <= is_timeout;

      if (sig_edge) begin
        cnt_q <= WIDTH'(1);
      end else if (cnt_q != MaxCnt) begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (sig_edge) begin
            state_q <= StArmed;
          end
        end
        StArmed, StTrack: begin
          if (take_meas) begin
            state_q <= StTrack;
            if (is_match) begin
              if (match_q != MatchMax) begin
                match_q <= match_q + 1'b1;
              end
              // Lock is judged on the post-increment match count.
              locked_o <= (match_q >= MatchMax - 1'b1);
            end else begin
              devider_o <= cnt_q;
              match_q   <= '0;
              locked_o  <= 1'b0;
            end
          end else if (is_timeout) begin
            state_q  <= StIdle;
            match_q  <= '0;
            locked_o <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef CLK_METER_LOSS_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      loss_cnt_o <= '0;
    end else if (lock_drop && (loss_cnt_o != 8'hff)) begin
      loss_cnt_o <= loss_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with a cycle-level reference model and literal pins.
module tb_clk_period_meter;

  localparam int unsigned W     = 16;
  localparam int unsigned LOCKN = 4;
  localparam int unsigned MAXC  = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig = 1'b0;
  logic [W-1:0] dev;
  logic         vld, lck, tmo;
  logic [7:0]   loss;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_period_meter #(
    .WIDTH      (W),
    .LOCK_COUNT (LOCKN),
    .MAX_COUNT  (MAXC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sig_i        (sig),
    .devider_o    (dev),
    .meas_valid_o (vld),
    .locked_o     (lck),
    .timeout_o    (tmo)
`ifdef CLK_METER_LOSS_CNT_EN
    ,
    .loss_cnt_o   (loss)
`endif
  );

`ifndef CLK_METER_LOSS_CNT_EN
  assign loss = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges are sig changes seen 3 cycles late; a measurement is the
  // distance between consecutive edges (capped at MAXC); locked means the last LOCKN
  // measurements since acquisition are all equal.
  logic    h[0:4];
  int      n = 0, n0 = 0, phase = 0, c;
  int      q[$];
  int      e_dev = 0, e_loss = 0;
  bit      e_vld = 0, e_lck = 0, e_tmo = 0, new_lck, chk_en = 0;

  always @(posedge clk) begin
    n++;
    if (rst) begin
      for (int i = 0; i < 5; i++) h[i] = 1'b0;
      n0 = n + 1; phase = 0; q.delete();
      e_dev = 0; e_vld = 0; e_lck = 0; e_tmo = 0; e_loss = 0; chk_en = 1;
    end else begin
      for (int i = 4; i > 0; i--) h[i] = h[i-1];
      h[0] = sig;
      c = n - n0;
      if (c > int'(MAXC)) c = MAXC;
      e_vld = 0; e_tmo = 0;
      if (h[3] != h[4]) begin
        if (phase == 0) phase = 1;
        else begin
          if (phase == 1) q.delete();
          q.push_back(c);
          if (q.size() > int'(LOCKN)) void'(q.pop_front());
          phase = 2; e_dev = c; e_vld = 1;
        end
        n0 = n;
      end else if (phase != 0 && c == int'(MAXC)) begin
        e_tmo = 1; phase = 0; q.delete();
      end
      new_lck = (q.size() == int'(LOCKN));
      foreach (q[i]) if (q[i] != q[0]) new_lck = 0;
      if (e_lck && !new_lck && e_loss < 255) e_loss++;
      e_lck = new_lck;
    end
  end

  int vld_cnt = 0, tmo_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("devider", 32'(dev), 32'(e_dev));
      check("meas_valid", 32'(vld), 32'(e_vld));
      check("locked", 32'(lck), 32'(e_lck));
      check("timeout", 32'(tmo), 32'(e_tmo));
`ifdef CLK_METER_LOSS_CNT_EN
      check("loss_cnt", 32'(loss), 32'(e_loss));
`endif
      if (vld) vld_cnt++;
      if (tmo) tmo_cnt++;
    end
  end

  task automatic toggle(input int gap, input int times);
    repeat (times) begin
      repeat (gap) @(negedge clk);
      sig = ~sig;
    end
  endtask

  int v0, t0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dev", 32'(dev), 0);
    check("rst_locked", 32'(lck), 0);
    check("rst_valid", 32'(vld), 0);
    check("rst_timeout", 32'(tmo), 0);
    rst = 1'b0;

    // Divider 4: 8 toggles give 7 measurements and lock
    v0 = vld_cnt;
    toggle(4, 8);
    repeat (6) @(negedge clk);
    check("t1_dev", 32'(dev), 4);
    check("t1_locked", 32'(lck), 1);
    check("t1_nvalid", 32'(vld_cnt - v0), 7);

    // Divider 1: one measurement per cycle
    toggle(1, 10);
    repeat (6) @(negedge clk);
    check("t2_dev", 32'(dev), 1);
    check("t2_locked", 32'(lck), 1);

    // Lock at 4, then switch to 7 and relock
    toggle(4, 6);
    toggle(7, 6);
    repeat (6) @(negedge clk);
    check("t3_dev", 32'(dev), 7);
    check("t3_locked", 32'(lck), 1);

    // Static input: single timeout pulse, value held
    t0 = tmo_cnt;
    repeat (120) @(negedge clk);
    check("t4_ntimeout", 32'(tmo_cnt - t0), 1);
    check("t4_locked", 32'(lck), 0);
    check("t4_dev_hold", 32'(dev), 7);
    v0 = vld_cnt;
    toggle(5, 1);
    repeat (6) @(negedge clk);
    check("t4_arm_novalid", 32'(vld_cnt - v0), 0);
    toggle(5, 1);
    repeat (6) @(negedge clk);
    check("t4_first_meas", 32'(vld_cnt - v0), 1);
    check("t4_dev", 32'(dev), 11);

    // Gap 106 times out; gaps of exactly MAXC measure MAXC without timeout
    t0 = tmo_cnt; v0 = vld_cnt;
    toggle(100, 3);
    repeat (6) @(negedge clk);
    check("max_ntimeout", 32'(tmo_cnt - t0), 1);
    check("max_nvalid", 32'(vld_cnt - v0), 2);
    check("max_dev", 32'(dev), MAXC);

    // Reset in the middle of tracking
    toggle(4, 6);
    if (sig) toggle(4, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_dev", 32'(dev), 0);
    check("t5_locked", 32'(lck), 0);
    check("t5_valid", 32'(vld), 0);
    v0 = vld_cnt;
    toggle(4, 1);
    repeat (6) @(negedge clk);
    check("t5_first_edge_novalid", 32'(vld_cnt - v0), 0);

`ifdef CLK_METER_LOSS_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      toggle(4, 5);
      toggle(6, 1);
    end
    repeat (6) @(negedge clk);
    check("loss_3", 32'(loss), 3);
    repeat (300) begin
      toggle(2, 1);
      toggle(1, 4);
    end
    toggle(3, 1);
    repeat (6) @(negedge clk);
    check("loss_sat", 32'(loss), 255);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
